fifo_rr_sched: RTL

//  Round-robin scheduler and read sequencer around one shared FIFO (WIDTH+IDW wide).

---
 rtl/fifo_rr_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_sched
//  Description : Round-robin write arbiter and read sequencer around a single
//                shared FIFO. Producers are tagged with their source ID on
//                the way in. On the way out, a 2-entry skid hides the FIFO's
//                1-cycle registered read latency and presents a valid/ready
//                stream {out_src, out_data}.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_sched #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH+IDW-1:0]   fifo_writeData,
    output logic                   fifo_writeEn,
    input  logic                   fifo_full,
    output logic                   fifo_readEn,
    input  logic [WIDTH+IDW-1:0]   fifo_readData,
    input  logic                   fifo_empty,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDW-1:0]         out_src,
    output logic                   busy
);

    localparam int C_FW = WIDTH + IDW;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW:0]     w_idx;
    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_grant_ok;

    // Find the first valid requester at or after rr_ptr, wrapping mod N_REQ.
    // The index is carried one bit wider so the wrap works for any N_REQ.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(N_REQ)) begin
                w_idx = w_idx - (IDW+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    // Mux the winner's payload out of the flat request bus.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_gnt_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant is only issued to a requester that is valid, so the grant
    // itself is the transfer; writes are held off whenever the FIFO is full.
    assign w_grant_ok = w_found & enable & ~fifo_full & rst_n;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = w_grant_ok & (w_gnt == IDW'(gi));
    end

    assign fifo_writeEn   = w_grant_ok;
    assign fifo_writeData = {w_gnt, w_gnt_data};

    // Advance the round-robin pointer just past the accepted requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_ok) begin
            r_rr_ptr <= (w_gnt == IDW'(N_REQ-1)) ? '0 : w_gnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [1:0]      r_held;
    logic            r_inflight;
    logic [C_FW-1:0] r_skid0;
    logic [C_FW-1:0] r_skid1;
    logic            w_pop;
    logic [2:0]      w_occ;

    assign out_valid = |r_held;
    assign w_pop     = out_valid & out_ready;

    // Occupancy after this cycle's pop: a new read may only be issued if the
    // word it returns is guaranteed a free skid slot.
    assign w_occ = {1'b0, r_held} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign fifo_readEn = rst_n & enable & ~fifo_empty & (w_occ < 3'd2);

    // Skid buffer: entry 0 is always the oldest word and drives the output.
    // The in-flight read lands here one cycle after readEn, even when
    // enable has since dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_held     <= 2'd0;
            r_inflight <= 1'b0;
            r_skid0    <= '0;
            r_skid1    <= '0;
        end else begin
            r_inflight <= fifo_readEn;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_held == 2'd0) begin
                        r_skid0 <= fifo_readData;
                    end else begin
                        r_skid1 <= fifo_readData;
                    end
                    r_held <= r_held + 2'd1;
                end
                2'b01: begin
                    r_skid0 <= r_skid1;
                    r_held  <= r_held - 2'd1;
                end
                2'b11: begin
                    if (r_held == 2'd1) begin
                        r_skid0 <= fifo_readData;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= fifo_readData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_skid0[WIDTH-1:0];
    assign out_src  = r_skid0[C_FW-1:WIDTH];
    assign busy     = ~fifo_empty | (|r_held) | r_inflight;

endmodule
`default_nettype wire
